// File: rtl/cp0_tlb_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_tlb_unit
// Purpose  : CP0 coprocessor. Holds the exception, timer and TLB-management
//            registers, and drives the TLB write port, the pipeline flush and
//            the redirect PC for the instruction retiring in WB.
// Ports    : clk/resetn        - clock, asynchronous active-low reset
//            ext_int           - level-sensitive external interrupt lines
//            wb_*              - retiring-instruction qualifiers and data
//            mtc0_we/cp0_addr/cp0_wdata/cp0_rdata - register access ({rd,sel})
//            tlbp_found/tlbp_index - TLB probe result
//            tlb_we/tlb_w_index/tlb_w_entry - TLB write port
//            tlb_r_index/tlb_r_entry        - TLB read port
//            entryhi_bus       - {VPN2, ASID} for lookups
//            flush/flush_pc    - pipeline cancel and redirect target
//            has_int           - pending enabled interrupt
// Revision : 1.0 - initial release
// ============================================================================
module cp0_tlb_unit #(
    parameter int IDXW     = 4,
    parameter int TICK_DIV = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [5:0]      ext_int,
    input  logic            wb_valid,
    input  logic            wb_ex,
    input  logic            wb_refill,
    input  logic            wb_bd,
    input  logic            wb_eret,
    input  logic            wb_tlbp,
    input  logic            wb_tlbr,
    input  logic            wb_tlbwi,
    input  logic            wb_tlbwr,
    input  logic [4:0]      wb_exccode,
    input  logic [31:0]     wb_pc,
    input  logic [31:0]     wb_badvaddr,
    input  logic            mtc0_we,
    input  logic [7:0]      cp0_addr,
    input  logic [31:0]     cp0_wdata,
    output logic [31:0]     cp0_rdata,
    input  logic            tlbp_found,
    input  logic [IDXW-1:0] tlbp_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic [77:0]     tlb_w_entry,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic [77:0]     tlb_r_entry,
    output logic [26:0]     entryhi_bus,
    output logic            flush,
    output logic [31:0]     flush_pc,
    output logic            has_int
);

    localparam int              c_DIVW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIVW-1:0] c_DIV_LAST = c_DIVW'(TICK_DIV - 1);
    localparam logic [IDXW-1:0] c_IDX_MAX  = {IDXW{1'b1}};

    localparam logic [7:0] c_A_INDEX   = 8'h00;
    localparam logic [7:0] c_A_RANDOM  = 8'h08;
    localparam logic [7:0] c_A_LO0     = 8'h10;
    localparam logic [7:0] c_A_LO1     = 8'h18;
    localparam logic [7:0] c_A_WIRED   = 8'h30;
    localparam logic [7:0] c_A_BADV    = 8'h40;
    localparam logic [7:0] c_A_COUNT   = 8'h48;
    localparam logic [7:0] c_A_EHI     = 8'h50;
    localparam logic [7:0] c_A_COMPARE = 8'h58;
    localparam logic [7:0] c_A_STATUS  = 8'h60;
    localparam logic [7:0] c_A_CAUSE   = 8'h68;
    localparam logic [7:0] c_A_EPC     = 8'h70;

    localparam logic [31:0] c_VEC_REFILL = 32'hbfc0_0200;
    localparam logic [31:0] c_VEC_GEN    = 32'hbfc0_0380;

    logic              r_index_p;
    logic [IDXW-1:0]   r_index;
    logic [IDXW-1:0]   r_random;
    logic [IDXW-1:0]   r_wired;
    logic [25:0]       r_lo0;        // {PFN, C, D, V, G}
    logic [25:0]       r_lo1;
    logic [18:0]       r_vpn2;
    logic [7:0]        r_asid;
    logic [31:0]       r_badvaddr;
    logic [31:0]       r_count;
    logic [c_DIVW-1:0] r_div;
    logic [31:0]       r_compare;
    logic [7:0]        r_im;
    logic              r_exl;
    logic              r_ie;
    logic              r_bd;
    logic              r_ti;
    logic [7:0]        r_ip;
    logic [4:0]        r_exccode;
    logic [31:0]       r_epc;

    // Exceptions suppress every other side effect of the retiring instruction.
    logic w_ex, w_commit, w_mtc0;
    logic w_eret, w_tlbp, w_tlbr, w_tlbwi, w_tlbwr;
    logic w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_wired, w_wr_count;
    logic w_wr_ehi, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
    logic w_code_tlb, w_code_badv;

    assign w_ex     = wb_valid & wb_ex;
    assign w_commit = wb_valid & ~wb_ex;
    assign w_mtc0   = w_commit & mtc0_we;
    assign w_eret   = w_commit & wb_eret;
    assign w_tlbp   = w_commit & wb_tlbp;
    assign w_tlbr   = w_commit & wb_tlbr;
    assign w_tlbwi  = w_commit & wb_tlbwi;
    assign w_tlbwr  = w_commit & wb_tlbwr;

    assign w_wr_index   = w_mtc0 & (cp0_addr == c_A_INDEX);
    assign w_wr_lo0     = w_mtc0 & (cp0_addr == c_A_LO0);
    assign w_wr_lo1     = w_mtc0 & (cp0_addr == c_A_LO1);
    assign w_wr_wired   = w_mtc0 & (cp0_addr == c_A_WIRED);
    assign w_wr_count   = w_mtc0 & (cp0_addr == c_A_COUNT);
    assign w_wr_ehi     = w_mtc0 & (cp0_addr == c_A_EHI);
    assign w_wr_compare = w_mtc0 & (cp0_addr == c_A_COMPARE);
    assign w_wr_status  = w_mtc0 & (cp0_addr == c_A_STATUS);
    assign w_wr_cause   = w_mtc0 & (cp0_addr == c_A_CAUSE);
    assign w_wr_epc     = w_mtc0 & (cp0_addr == c_A_EPC);

    // Mod/TLBL/TLBS also capture the faulting VPN2; AdEL/AdES only BadVAddr.
    assign w_code_tlb  = (wb_exccode >= 5'd1) && (wb_exccode <= 5'd3);
    assign w_code_badv = (wb_exccode >= 5'd1) && (wb_exccode <= 5'd5);

    // ------------------------------------------------------------------ read
    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            c_A_INDEX:   cp0_rdata = {r_index_p, {(31-IDXW){1'b0}}, r_index};
            c_A_RANDOM:  cp0_rdata = {{(32-IDXW){1'b0}}, r_random};
            c_A_LO0:     cp0_rdata = {6'h0, r_lo0};
            c_A_LO1:     cp0_rdata = {6'h0, r_lo1};
            c_A_WIRED:   cp0_rdata = {{(32-IDXW){1'b0}}, r_wired};
            c_A_BADV:    cp0_rdata = r_badvaddr;
            c_A_COUNT:   cp0_rdata = r_count;
            c_A_EHI:     cp0_rdata = {r_vpn2, 5'h0, r_asid};
            c_A_COMPARE: cp0_rdata = r_compare;
            c_A_STATUS:  cp0_rdata = {9'h0, 1'b1, 6'h0, r_im, 6'h0, r_exl, r_ie};
            c_A_CAUSE:   cp0_rdata = {r_bd, r_ti, 14'h0, r_ip, 1'b0, r_exccode, 2'b00};
            c_A_EPC:     cp0_rdata = r_epc;
            default:     cp0_rdata = 32'h0;
        endcase
    end

    // ------------------------------------------------------------ TLB ports
    assign tlb_we      = w_tlbwi | w_tlbwr;
    assign tlb_w_index = w_tlbwr ? r_random : r_index;
    // Global bit is stored per EntryLo but the TLB keeps a single one.
    assign tlb_w_entry = {r_vpn2, r_asid, r_lo0[0] & r_lo1[0], r_lo0[25:1], r_lo1[25:1]};
    assign tlb_r_index = r_index;
    assign entryhi_bus = {r_vpn2, r_asid};

    // --------------------------------------------------------- flush / int
    assign flush = wb_valid & (wb_ex | wb_eret | wb_tlbr | wb_tlbwi | wb_tlbwr);

    always_comb begin
        if (wb_ex)
            flush_pc = (wb_refill && !r_exl) ? c_VEC_REFILL : c_VEC_GEN;
        else if (wb_eret)
            flush_pc = r_epc;
        else
            flush_pc = wb_pc + 32'd4;
    end

    assign has_int = (|(r_ip & r_im)) & r_ie & ~r_exl;

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_index_p  <= 1'b0;
            r_index    <= '0;
            r_random   <= c_IDX_MAX;
            r_wired    <= '0;
            r_lo0      <= '0;
            r_lo1      <= '0;
            r_vpn2     <= '0;
            r_asid     <= '0;
            r_badvaddr <= '0;
            r_count    <= '0;
            r_div      <= '0;
            r_compare  <= '0;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip       <= '0;
            r_exccode  <= '0;
            r_epc      <= '0;
        end else begin
            // Index: a probe miss keeps the old index and only raises P.
            if (w_tlbp) begin
                r_index_p <= ~tlbp_found;
                if (tlbp_found)
                    r_index <= tlbp_index;
            end else if (w_wr_index) begin
                r_index <= cp0_wdata[IDXW-1:0];
            end

            if (w_ex && w_code_tlb)
                r_vpn2 <= wb_badvaddr[31:13];
            else if (w_tlbr)
                r_vpn2 <= tlb_r_entry[77:59];
            else if (w_wr_ehi)
                r_vpn2 <= cp0_wdata[31:13];

            if (w_tlbr)
                r_asid <= tlb_r_entry[58:51];
            else if (w_wr_ehi)
                r_asid <= cp0_wdata[7:0];

            if (w_tlbr) begin
                r_lo0 <= {tlb_r_entry[49:25], tlb_r_entry[50]};
                r_lo1 <= {tlb_r_entry[24:0],  tlb_r_entry[50]};
            end else begin
                if (w_wr_lo0) r_lo0 <= cp0_wdata[25:0];
                if (w_wr_lo1) r_lo1 <= cp0_wdata[25:0];
            end

            if (w_wr_wired)
                r_wired <= cp0_wdata[IDXW-1:0];

            // Random wraps to the top once it reaches the wired boundary.
            if (w_wr_wired || (r_random <= r_wired))
                r_random <= c_IDX_MAX;
            else
                r_random <= r_random - 1'b1;

            if (w_ex && w_code_badv)
                r_badvaddr <= wb_badvaddr;

            if (w_wr_count) begin
                r_count <= cp0_wdata;
                r_div   <= '0;
            end else if (r_div == c_DIV_LAST) begin
                r_div   <= '0;
                r_count <= r_count + 32'd1;
            end else begin
                r_div   <= r_div + 1'b1;
            end

            if (w_wr_compare)
                r_compare <= cp0_wdata;

            if (w_wr_compare)
                r_ti <= 1'b0;
            else if (r_count == r_compare)
                r_ti <= 1'b1;

            r_ip[7:2] <= {ext_int[5] | r_ti, ext_int[4:0]};
            if (w_wr_cause)
                r_ip[1:0] <= cp0_wdata[9:8];

            if (w_wr_status) begin
                r_im <= cp0_wdata[15:8];
                r_ie <= cp0_wdata[0];
            end

            if (w_ex)
                r_exl <= 1'b1;
            else if (w_eret)
                r_exl <= 1'b0;
            else if (w_wr_status)
                r_exl <= cp0_wdata[1];

            if (w_ex)
                r_exccode <= wb_exccode;

            // Nested exceptions keep the original return point.
            if (w_ex && !r_exl) begin
                r_bd  <= wb_bd;
                r_epc <= wb_pc - (wb_bd ? 32'd4 : 32'd0);
            end else if (w_wr_epc) begin
                r_epc <= cp0_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cp0_tlb_unit.md
# cp0_tlb_unit

Parametrised CP0 coprocessor, split out of the writeback stage so the TLB size and timer rate are configurable. It holds the exception, timer and TLB-management registers, and it generates the flush request and redirect PC. It adds Random/Wired registers with `tlbwr`, refill-vector selection, and BadVAddr/EntryHi capture on TLB exceptions. WB drives it combinationally in the same cycle the instruction retires.

## Interface
- `IDXW`, default 4: TLB index width; TLBNUM = 2^IDXW, allowed range 1..6.
- `TICK_DIV`, default 2: Count increments once every TICK_DIV cycles; must be ≥1.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `ext_int` in 6: external interrupt lines, level-sensitive.
- `wb_valid`, `wb_ex`, `wb_refill`, `wb_bd`, `wb_eret`, `wb_tlbp`, `wb_tlbr`, `wb_tlbwi`, `wb_tlbwr` in 1 each: retiring-instruction qualifiers. `wb_refill` means a TLB miss, as opposed to an invalid or modified entry.
- `wb_exccode` in 5, `wb_pc` in 32, `wb_badvaddr` in 32: exception data.
- `mtc0_we` in 1, `cp0_addr` in 8 ({rd,sel}), `cp0_wdata` in 32: register write port.
- `cp0_rdata` out 32: combinational read of `cp0_addr`; unmapped addresses read 0.
- `tlbp_found` in 1, `tlbp_index` in IDXW: TLB search result, valid when `wb_tlbp`.
- `tlb_we` out 1, `tlb_w_index` out IDXW, `tlb_w_entry` out 78: TLB write port.
- `tlb_r_index` out IDXW, `tlb_r_entry` in 78: TLB read port.
- `entryhi_bus` out 27: {VPN2, ASID} for instruction/data lookups.
- `flush` out 1, `flush_pc` out 32: pipeline cancel and redirect target.
- `has_int` out 1: pending enabled interrupt, sent to EX for tagging.

Entry packing, MSB first: vpn2[19], asid[8], g, pfn0[20], c0[3], d0, v0, pfn1[20], c1[3], d1, v1.

## Operation
- Register map (rd,sel):
  - Index (0,0): P[31], index[IDXW-1:0]
  - Random (1,0): read-only
  - EntryLo0/1 (2,0)/(3,0): PFN[25:6], C[5:3], D, V, G
  - Wired (6,0): [IDXW-1:0]
  - BadVAddr (8,0): read-only
  - Count (9,0)
  - EntryHi (10,0): VPN2[31:13], ASID[7:0]
  - Compare (11,0)
  - Status (12,0): BEV[22] read-only =1, IM[15:8], EXL[1], IE[0]
  - Cause (13,0): BD[31], TI[30], IP[15:8] (only IP[1:0] writable), ExcCode[6:2]
  - EPC (14,0)
- Qualifier: ex = `wb_valid & wb_ex`. Every other write is gated by `wb_valid & !ex`.
- Exception writes:
  - EXL←1 and ExcCode←code on every exception.
  - EPC (pc−4 if bd, else pc) and BD are written only if EXL was 0.
  - Exccode 1/2/3/4/5 (Mod, TLBL, TLBS, AdEL, AdES): BadVAddr←badvaddr.
  - Exccode 1/2/3 additionally: EntryHi.VPN2←badvaddr[31:13].
- Eret: EXL←0.
- Priority per field: exception > eret > tlbr/tlbp > mtc0.
- TLB operations:
  - tlbp: P←!found, and index←tlbp_index only when found.
  - tlbr: reads entry at Index into EntryHi and both EntryLos; G from the TLB is copied into both EntryLos.
  - tlbwi: writes at Index. tlbwr: writes at Random.
  - On write, g = G0 & G1. `tlb_we` is combinational.
- Random:
  - Decrements each cycle.
  - When Random == Wired (or 0), the next value is TLBNUM−1.
  - Writing Wired forces Random to TLBNUM−1 on the next cycle.
  - Random never reads below Wired unless Wired > TLBNUM−1, in which case Random stays at TLBNUM−1.
- Timer:
  - Divider counter advances modulo TICK_DIV; Count+1 on wrap.
  - mtc0 Count loads the value and clears the divider.
  - TI←1 when Count == Compare (registered values); mtc0 Compare clears TI, and the clear wins over a same-cycle set.
- Interrupts:
  - Each cycle, IP[7] ← ext_int[5] | TI and IP[6:2] ← ext_int[4:0].
  - has_int = |(IP & IM) & IE & !EXL.
- Flush:
  - flush = wb_valid & (wb_ex | eret | tlbr | tlbwi | tlbwr).
  - flush_pc:
    - tlb ops: pc+4
    - eret: EPC
    - refill exception with EXL=0: 0xbfc00200
    - any other exception: 0xbfc00380

## Timing
- Reset (resetn low, asynchronous):
  - All registers 0, except Random = TLBNUM−1 and BEV = 1.
  - Outputs: flush=0, tlb_we=0, has_int=0, entryhi_bus=0.
- Register writes are committed at the clock edge. A read in the following cycle returns the new value; there is no same-cycle bypass.
- `cp0_rdata`, `flush`, `flush_pc`, `tlb_*` are combinational from inputs and current registers, with zero latency.
- IP follows ext_int one cycle late; has_int follows IP combinationally.
- Deasserting resetn mid-stream restarts the divider at 0 and Random at TLBNUM−1.

## Test plan
- Reset → Status=0x00400000, Random=15 (IDXW=4), Cause=0, flush=0.
- Count test: TICK_DIV=2, mtc0 Count=0 and Compare=5 → TI sets after 10 cycles. mtc0 IM[7]=1 and IE=1 → has_int=1 next cycle. mtc0 Compare → TI and has_int clear.
- Random test: Wired=4 → Random sequence 15,14,…,4,15.
- tlbwr test: tlbwr while Random=9 → tlb_we=1, tlb_w_index=9, flush_pc=pc+4.
- TLB exceptions:
  - Refill TLBL at pc 0x80001000, bd=1, badvaddr 0x00402ABC, EXL=0 → EPC=0x80000FFC, BD=1, BadVAddr set, VPN2=0x00201, flush_pc=0xbfc00200.
  - Second refill with EXL=1 → EPC unchanged, flush_pc=0xbfc00380.
- Priority: exception and mtc0 Status in the same cycle → mtc0 dropped. tlbp miss → P=1, index unchanged. Eret → EXL=0, flush_pc=EPC.
